// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, DRAIN} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } fd_reg_t;
endpackage

// File: rtl/fetch_sequencer_add.sv
// Plain combinational adder, used for the sequential PC increment.
module Add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage: owns the PC, runs the single-outstanding imem handshake and
// loads the Fetch->Decode register, honouring stall and branch redirects.
module fetch_sequencer
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     BOOT_DELAY   = 4
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            stall_i,
  input  logic            PCSrc_i,
  input  logic [XLEN-1:0] PCTarget_i,
  input  logic            imem_ready_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  output logic [XLEN-1:0] pc_DECODE_o,
  output logic [XLEN-1:0] instruction_DECODE_o,
  output logic            valid_DECODE_o,
  output logic            flush_o
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  logic [XLEN-1:0] hold_q, hold_d;
  logic [3:0]      boot_cnt_q, boot_cnt_d;
  fd_reg_t         fd_q, fd_d;
  logic            flush_q, flush_d;
  logic            redirect, load_mem, load_hold;

  Add #(.W(XLEN)) u_pc_add (.a(pc_q), .b(32'd4), .y(pc_plus4));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      hold_q     <= '0;
      boot_cnt_q <= '0;
      fd_q       <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      boot_cnt_q <= boot_cnt_d;
      fd_q       <= fd_d;
      flush_q    <= flush_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    boot_cnt_d = boot_cnt_q;
    fd_d       = fd_q;
    flush_d    = 1'b0;
    load_mem   = 1'b0;
    load_hold  = 1'b0;
    redirect   = PCSrc_i && (state_q != BOOT);

    case (state_q)
      BOOT: begin
        if (boot_cnt_q == 4'(BOOT_DELAY - 1)) state_d = REQ;
        else boot_cnt_d = boot_cnt_q + 4'd1;
      end
      REQ: if (imem_ready_i) state_d = redirect ? DRAIN : WAIT;
      WAIT: begin
        if (imem_rvalid_i) begin
          if (redirect)      state_d = REQ;
          else if (!stall_i) begin load_mem = 1'b1; state_d = REQ; end
          else begin hold_d = imem_rdata_i; state_d = HOLD; end
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (redirect)      state_d = REQ;
        else if (!stall_i) begin load_hold = 1'b1; state_d = REQ; end
      end
      DRAIN: if (imem_rvalid_i) state_d = REQ;
      default: state_d = BOOT;
    endcase

    // Redirect beats stall and any same-cycle response; otherwise load or bubble.
    if (redirect) begin
      pc_d    = PCTarget_i & ~32'h3;
      fd_d    = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
      flush_d = 1'b1;
    end else if (load_mem || load_hold) begin
      fd_d = '{pc: pc_q, instr: load_mem ? imem_rdata_i : hold_q, valid: 1'b1};
      pc_d = pc_plus4;
    end else if (!stall_i) begin
      fd_d.valid = 1'b0;
      fd_d.instr = NOP_INSTR;
    end
  end

  assign imem_req_o           = (state_q == REQ);
  assign imem_addr_o          = pc_q;
  assign pc_DECODE_o          = fd_q.pc;
  assign instruction_DECODE_o = fd_q.instr;
  assign valid_DECODE_o       = fd_q.valid;
  assign flush_o              = flush_q;
endmodule
